// File: rtl/delay_sum_ch.sv
// ---------------------------------------------------------------------------
// delay_sum_ch
//
// Multi-channel delay-and-sum beamformer core. NUM_CH signed sample streams
// arrive in lockstep. Each channel is delayed by its own runtime-programmable
// sample count through a per-channel ring buffer. The delayed samples are
// then summed into one beamformed output sample.
//
// A shared fill counter records how much history the rings hold. Any tap that
// would reach past that history is forced to zero, so stale ring contents
// (which reset does not clear) can never reach the output.
//
// Pipeline:
//   stage 1 : per-channel masked taps registered
//   stage 2 : sign-extended sum registered onto dout
//   dout_valid trails din_valid by exactly two cycles.
//
// Optional feature (macro DELAY_SUM_SAT_EN):
//   defined   - the sum is saturated to the signed DATA_WIDTH range, then
//               sign-extended onto dout; ovf is a sticky clip flag.
//   undefined - dout carries the full-growth sum and ovf is tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   din        in   packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   din_valid  in   one sample set accepted per asserted cycle
//   cfg_we     in   write strobe for a channel delay
//   cfg_ch     in   channel index for cfg_we (indices >= NUM_CH are ignored)
//   cfg_delay  in   new delay in samples, clamped to MAX_DELAY-1
//   dout       out  signed delayed sum, DATA_WIDTH+SUM_GROW bits
//   dout_valid out  dout qualifier
//   ovf        out  sticky saturation flag (0 unless DELAY_SUM_SAT_EN)
//   primed     out  every channel has full history for its current delay
// ---------------------------------------------------------------------------
module delay_sum_ch #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_CH        = 4,
  parameter int MAX_DELAY     = 64,
  parameter int DELAY_WIDTH   = 8,
  parameter int DEFAULT_DELAY = 3,
  parameter int SUM_GROW      = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0]        din,
  input  logic                                din_valid,
  input  logic                                cfg_we,
  input  logic [7:0]                          cfg_ch,
  input  logic [DELAY_WIDTH-1:0]              cfg_delay,
  output logic signed [DATA_WIDTH+SUM_GROW-1:0] dout,
  output logic                                dout_valid,
  output logic                                ovf,
  output logic                                primed
);

  localparam int PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int SUM_W = DATA_WIDTH + SUM_GROW;

  // Largest legal delay. It is also the saturation point of the fill counter.
  localparam logic [PTR_W-1:0] FILL_MAX = PTR_W'(MAX_DELAY - 1);
  localparam logic [DELAY_WIDTH-1:0] DELAY_CAP = DELAY_WIDTH'(MAX_DELAY - 1);
  localparam logic [PTR_W-1:0] RESET_DELAY =
    (DEFAULT_DELAY > MAX_DELAY - 1) ? FILL_MAX : PTR_W'(DEFAULT_DELAY);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        fill;
  logic [PTR_W-1:0]        delay     [NUM_CH];
  logic [PTR_W-1:0]        rd_idx    [NUM_CH];
  sample_t                 ring      [NUM_CH][MAX_DELAY];
  sample_t                 din_ch    [NUM_CH];
  sample_t                 tap       [NUM_CH];
  sample_t                 s1_tap    [NUM_CH];
  logic                    s1_valid;
  logic [PTR_W-1:0]        max_delay;
  logic [PTR_W-1:0]        cfg_value;
  logic signed [SUM_W-1:0] sum;

  // Split the packed input bus into per-channel samples.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      din_ch[k] = din[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Tap selection. The read happens before this cycle's write.
  // The pointer difference wraps naturally because MAX_DELAY is a power of 2.
  // A zero delay bypasses the ring and uses the live sample. A tap that needs
  // more history than has been written since reset is forced to zero.
  // Because delays never exceed FILL_MAX, a saturated fill count always
  // means the history is complete.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      rd_idx[k] = wr_ptr - delay[k];
      tap[k]    = '0;
      if (delay[k] == '0) begin
        tap[k] = din_ch[k];
      end else if (fill >= delay[k]) begin
        tap[k] = ring[k][rd_idx[k]];
      end
    end
  end

  // Deepest delay currently programmed. It drives the primed flag.
  always_comb begin
    max_delay = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (delay[k] > max_delay) begin
        max_delay = delay[k];
      end
    end
  end

  // Requested delays beyond the ring depth clamp to the deepest legal tap.
  always_comb begin
    cfg_value = cfg_delay[PTR_W-1:0];
    if (cfg_delay > DELAY_CAP) begin
      cfg_value = FILL_MAX;
    end
  end

  // Ring storage. It is deliberately not reset; the fill count masks
  // whatever was left behind.
  always_ff @(posedge clk) begin
    if (!reset && din_valid) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ring[k][wr_ptr] <= din_ch[k];
      end
    end
  end

  // Write pointer, fill tracking, delay registers and the stage-1 taps.
  // A delay written together with a sample takes effect from the next sample,
  // because this cycle's taps were already selected using the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      fill     <= '0;
      s1_valid <= 1'b0;
      primed   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        delay[k]  <= RESET_DELAY;
        s1_tap[k] <= '0;
      end
    end else begin
      s1_valid <= din_valid;
      primed   <= (fill >= max_delay);
      if (din_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) begin
          fill <= fill + 1'b1;
        end
        for (int k = 0; k < NUM_CH; k++) begin
          s1_tap[k] <= tap[k];
        end
      end
      if (cfg_we) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (32'(cfg_ch) == k) begin
            delay[k] <= cfg_value;
          end
        end
      end
    end
  end

  // Sign-extend each tap to the full growth width before accumulating.
  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = sum + SUM_W'(s1_tap[k]);
    end
  end

`ifdef DELAY_SUM_SAT_EN
  localparam logic signed [SUM_W-1:0] SAT_HI =
    {{(SUM_GROW+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO =
    {{(SUM_GROW+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic                    clip_hi;
  logic                    clip_lo;
  logic signed [SUM_W-1:0] sat_sum;

  // Clamp the sum to the signed range of a single input sample.
  always_comb begin
    clip_hi = (sum > SAT_HI);
    clip_lo = (sum < SAT_LO);
    sat_sum = sum;
    if (clip_hi) begin
      sat_sum = SAT_HI;
    end else if (clip_lo) begin
      sat_sum = SAT_LO;
    end
  end

  // Stage 2 with saturation. ovf latches on any clipped valid output.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        dout <= sat_sum;
        if (clip_hi || clip_lo) begin
          ovf <= 1'b1;
        end
      end
    end
  end
`else
  // Stage 2 at full growth width. The sum cannot overflow here.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        dout <= sum;
      end
    end
  end

  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_delay_sum_ch.sv
// ---------------------------------------------------------------------------
// tb_delay_sum_ch
//
// Directed bench for delay_sum_ch with the default parameters
// (4 channels, 16-bit samples, 64-deep rings, default delay 3).
// Inputs change 1 ns after the rising edge. Outputs are sampled at the
// same point, so every check sees the state left by the preceding edge.
// ---------------------------------------------------------------------------
module tb_delay_sum_ch;

  logic               clk = 1'b0;
  logic               reset;
  logic [63:0]        din;
  logic               din_valid;
  logic               cfg_we;
  logic [7:0]         cfg_ch;
  logic [7:0]         cfg_delay;
  logic signed [17:0] dout;
  logic               dout_valid;
  logic               ovf;
  logic               primed;

  int n_cmp  = 0;
  int n_fail = 0;

  // Hand-computed outputs for the ramp din_k[n] = n + 100*k.
  // Delays start at 0/1/2/3. Channel 1 moves to 5 from n = 11, and to 63
  // (clamped from 200) from n = 15.
  int ramp_exp [16] = '{0, 101, 303, 606, 610, 614, 618, 622,
                        626, 630, 634, 634, 638, 642, 646, 540};

  delay_sum_ch dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_delay  (cfg_delay),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ovf        (ovf),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int d0, input int d1, input int d2,
                                input int d3, input logic v);
    din       = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    din_valid = v;
  endtask

  task automatic set_delay(input int ch, input int d);
    cfg_we    = 1'b1;
    cfg_ch    = 8'(ch);
    cfg_delay = 8'(d);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    cfg_we    = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_delay = '0;
    $display("[TB] start");

    // Reset state.
    tick();
    tick();
    check_output("rst_dout", $signed(dout), 0);
    check_output("rst_dout_valid", {31'b0, dout_valid}, 0);
    check_output("rst_ovf", {31'b0, ovf}, 0);
    check_output("rst_primed", {31'b0, primed}, 0);
    reset = 1'b0;

    // Ramp with a config collision at n = 10 and a clamped write at n = 14.
    set_delay(0, 0);
    set_delay(1, 1);
    set_delay(2, 2);
    set_delay(3, 3);
    for (int n = 0; n < 16; n++) begin
      cfg_ch    = 8'd1;
      cfg_we    = (n == 10) || (n == 14);
      cfg_delay = (n == 14) ? 8'd200 : 8'd5;
      apply_stimulus(n, n + 100, n + 200, n + 300, 1'b1);
      tick();
      cfg_we = 1'b0;
      check_output($sformatf("ramp_primed_%0d", n), {31'b0, primed},
                   ((n >= 3) && (n < 15)) ? 1 : 0);
      if (n >= 1) begin
        check_output($sformatf("ramp_valid_%0d", n - 1), {31'b0, dout_valid}, 1);
        check_output($sformatf("ramp_dout_%0d", n - 1), $signed(dout), ramp_exp[n-1]);
      end
    end
    apply_stimulus(0, 0, 0, 0, 1'b0);
    tick();
    check_output("ramp_valid_15", {31'b0, dout_valid}, 1);
    check_output("ramp_dout_15", $signed(dout), ramp_exp[15]);
    tick();
    check_output("ramp_tail_valid", {31'b0, dout_valid}, 0);
    check_output("ramp_tail_hold", $signed(dout), ramp_exp[15]);

    // Gapped ramp: valid on even cycles only.
    do_reset();
    set_delay(0, 0);
    set_delay(1, 1);
    set_delay(2, 2);
    set_delay(3, 3);
    for (int c = 0; c < 13; c++) begin
      if (c % 2 == 0) begin
        apply_stimulus(c / 2, c / 2 + 100, c / 2 + 200, c / 2 + 300, 1'b1);
      end else begin
        apply_stimulus(0, 0, 0, 0, 1'b0);
      end
      tick();
      if (c >= 1) begin
        check_output($sformatf("gap_valid_%0d", c), {31'b0, dout_valid},
                     ((c - 1) % 2 == 0) ? 1 : 0);
        check_output($sformatf("gap_dout_%0d", c), $signed(dout), ramp_exp[(c-1)/2]);
      end
    end

    // Wrap: channel 0 at delay 63 (clamped from 200), the others silent.
    do_reset();
    set_delay(0, 200);
    for (int n = 0; n < 200; n++) begin
      apply_stimulus(n, 0, 0, 0, 1'b1);
      tick();
      if (n >= 1) begin
        check_output($sformatf("wrap_dout_%0d", n - 1), $signed(dout),
                     (n - 1 >= 63) ? (n - 1 - 63) : 0);
      end
    end
    apply_stimulus(0, 0, 0, 0, 1'b0);
    tick();
    check_output("wrap_dout_199", $signed(dout), 136);
    check_output("wrap_primed", {31'b0, primed}, 1);

    // Full-scale sums with all delays at zero.
    do_reset();
    set_delay(0, 0);
    set_delay(1, 0);
    set_delay(2, 0);
    set_delay(3, 0);
    apply_stimulus(32767, 32767, 32767, 32767, 1'b1);
    tick();
    apply_stimulus(-32768, -32768, -32768, -32768, 1'b1);
    tick();
`ifdef DELAY_SUM_SAT_EN
    check_output("sat_pos_dout", $signed(dout), 32767);
    check_output("sat_pos_ovf", {31'b0, ovf}, 1);
`else
    check_output("sat_pos_dout", $signed(dout), 131068);
    check_output("sat_pos_ovf", {31'b0, ovf}, 0);
`endif
    apply_stimulus(1, 1, 1, 1, 1'b1);
    tick();
`ifdef DELAY_SUM_SAT_EN
    check_output("sat_neg_dout", $signed(dout), -32768);
`else
    check_output("sat_neg_dout", $signed(dout), -131072);
`endif
    apply_stimulus(0, 0, 0, 0, 1'b0);
    tick();
    check_output("sat_small_dout", $signed(dout), 4);
`ifdef DELAY_SUM_SAT_EN
    check_output("sat_sticky_ovf", {31'b0, ovf}, 1);
`else
    check_output("sat_sticky_ovf", {31'b0, ovf}, 0);
`endif

    // Mid-stream reset at n = 20.
    do_reset();
    set_delay(0, 0);
    set_delay(1, 1);
    set_delay(2, 2);
    set_delay(3, 3);
    for (int n = 0; n < 20; n++) begin
      apply_stimulus(n, n + 100, n + 200, n + 300, 1'b1);
      tick();
    end
    check_output("mid_pre_primed", {31'b0, primed}, 1);
    apply_stimulus(20, 120, 220, 320, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 1'b0);
    check_output("mid_rst_valid", {31'b0, dout_valid}, 0);
    check_output("mid_rst_primed", {31'b0, primed}, 0);
    check_output("mid_rst_dout", $signed(dout), 0);
    tick();
    check_output("mid_flush_valid1", {31'b0, dout_valid}, 0);
    tick();
    check_output("mid_flush_valid2", {31'b0, dout_valid}, 0);
    // Only channel 0 is reprogrammed. The rest must be back at delay 3.
    set_delay(0, 0);
    for (int n = 0; n < 4; n++) begin
      apply_stimulus(10 + n, 20 + n, 30 + n, 40 + n, 1'b1);
      tick();
      if (n >= 1) begin
        check_output($sformatf("restart_dout_%0d", n - 1), $signed(dout), 10 + n - 1);
      end
    end
    apply_stimulus(0, 0, 0, 0, 1'b0);
    tick();
    check_output("restart_dout_3", $signed(dout), 103);
    check_output("restart_valid_3", {31'b0, dout_valid}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
